// File: rtl/hack_io_pkg.sv
// Shared constants for the Hack I/O controller: bus widths, register offsets, event bit indices.
package hack_io_pkg;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        IO_LED  = 3'd0,
        IO_DIR  = 3'd1,
        IO_OUT  = 3'd2,
        IO_IN   = 3'd3,
        IO_EVT  = 3'd4,
        IO_IEN  = 3'd5,
        IO_RSV6 = 3'd6,
        IO_RSV7 = 3'd7
    } ioReg_e;

    localparam int unsigned EVT_RISE = 0;
    localparam int unsigned EVT_FALL = 1;

endpackage

// File: rtl/hack_io_gpio_in.sv
// GPIO input path: 2-flop synchroniser, optional debounce (HACK_IO_CTRL_DEBOUNCE_EN),
// post-reset arming and edge detection.
module hack_io_gpio_in
    import hack_io_pkg::*;
`ifdef HACK_IO_CTRL_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic CLK,
    input  logic RST,
    input  logic pinRaw,
    output logic f,
    output logic risePulse,
    output logic fallPulse
);

    logic       sync0;
    logic       sync1;
    logic       fD;
    logic       armed;
    logic [1:0] armCnt;

    // armed is registered off the saturated counter so fD has caught up with f
    // before the first edge can be reported.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            fD     <= 1'b0;
            armCnt <= '0;
            armed  <= 1'b0;
        end else begin
            sync0 <= pinRaw;
            sync1 <= sync0;
            fD    <= f;
            if (armCnt != 2'd3) begin
                armCnt <= armCnt + 2'd1;
            end
            armed <= (armCnt == 2'd3);
        end
    end

`ifdef HACK_IO_CTRL_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] dbCnt;

    // Counts consecutive cycles sync1 disagrees with f; any return to f restarts it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dbCnt <= '0;
            f     <= 1'b0;
        end else if (sync1 == f) begin
            dbCnt <= '0;
        end else if (dbCnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            dbCnt <= '0;
            f     <= sync1;
        end else begin
            dbCnt <= dbCnt + CNT_W'(1);
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            f <= 1'b0;
        end else begin
            f <= sync1;
        end
    end
`endif

    assign risePulse = armed &  f & ~fD;
    assign fallPulse = armed & ~f &  fD;

endmodule

// File: rtl/hack_io_ctrl.sv
// Memory-mapped I/O controller for the Hack ioports block: write strobes, GPIO events, irq, read-back.
// Optional GPIO debounce enabled by defining HACK_IO_CTRL_DEBOUNCE_EN.
module hack_io_ctrl
    import hack_io_pkg::*;
#(
    parameter logic [ADDR_W-1:0] IO_BASE         = 15'h6100,
    parameter int unsigned       DEBOUNCE_CYCLES = 16
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] addressM,
    input  logic              writeM,
    input  logic [DATA_W-1:0] outM,
    output logic [DATA_W-1:0] ioRdata,
    output logic              ioHit,
    output logic              dataIn,
    output logic              ledLoad,
    output logic              gpioDir,
    output logic              gpioLoad,
    input  logic              dataOut,
    output logic              irq
);

    if (DEBOUNCE_CYCLES < 2) begin : gBadDebounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic [ADDR_W-1:0] offset;
    logic              inWin;
    logic              wrEn;
    ioReg_e            regSel;

    logic              ledReg;
    logic              dirReg;
    logic              outReg;
    logic [1:0]        ienReg;
    logic [1:0]        evtReg;
    logic [1:0]        evtNext;
    logic [DATA_W-1:0] rdNext;

    logic              f;
    logic              risePulse;
    logic              fallPulse;
    logic              unusedBits;

    // Unsigned subtraction makes addresses below the base wrap high, so one compare bounds both ends.
    assign offset     = addressM - IO_BASE;
    assign inWin      = (offset < ADDR_W'(8));
    assign regSel     = ioReg_e'(offset[2:0]);
    assign wrEn       = writeM & inWin;
    assign unusedBits = ^outM[DATA_W-1:2];

    hack_io_gpio_in
`ifdef HACK_IO_CTRL_DEBOUNCE_EN
        #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
        uGpioIn (
            .CLK       (CLK),
            .RST       (RST),
            .pinRaw    (dataOut),
            .f         (f),
            .risePulse (risePulse),
            .fallPulse (fallPulse)
        );

    // Clear is applied before set so a same-cycle hardware event survives the W1C.
    always_comb begin
        evtNext = evtReg;
        if (wrEn && regSel == IO_EVT) begin
            evtNext = evtReg & ~outM[1:0];
        end
        if (risePulse) begin
            evtNext[EVT_RISE] = 1'b1;
        end
        if (fallPulse) begin
            evtNext[EVT_FALL] = 1'b1;
        end
    end

    always_comb begin
        rdNext = '0;
        if (inWin) begin
            case (regSel)
                IO_LED:  rdNext[0]   = ledReg;
                IO_DIR:  rdNext[0]   = dirReg;
                IO_OUT:  rdNext[0]   = outReg;
                IO_IN:   rdNext[0]   = f;
                IO_EVT:  rdNext[1:0] = evtReg;
                IO_IEN:  rdNext[1:0] = ienReg;
                default: rdNext      = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ledReg   <= 1'b0;
            dirReg   <= 1'b0;
            outReg   <= 1'b0;
            ienReg   <= '0;
            evtReg   <= '0;
            dataIn   <= 1'b0;
            ledLoad  <= 1'b0;
            gpioDir  <= 1'b0;
            gpioLoad <= 1'b0;
            ioRdata  <= '0;
            ioHit    <= 1'b0;
            irq      <= 1'b0;
        end else begin
            ledLoad  <= wrEn && (regSel == IO_LED);
            gpioDir  <= wrEn && (regSel == IO_DIR);
            gpioLoad <= wrEn && (regSel == IO_OUT);
            dataIn   <= (wrEn && (regSel inside {IO_LED, IO_DIR, IO_OUT})) ? outM[0] : 1'b0;

            if (wrEn) begin
                case (regSel)
                    IO_LED:  ledReg <= outM[0];
                    IO_DIR:  dirReg <= outM[0];
                    IO_OUT:  outReg <= outM[0];
                    IO_IEN:  ienReg <= outM[1:0];
                    default: ;
                endcase
            end

            evtReg  <= evtNext;
            irq     <= |(evtReg & ienReg);
            ioRdata <= rdNext;
            ioHit   <= inWin;
        end
    end

endmodule
